// File: rtl/ahb_vic_slave.sv
// ahb_vic_slave: AHB-Lite vectored interrupt controller slave.
// Level sources plus software bits are masked by ENABLE. The lowest-index active
// channel wins and drives VECTOR and IRQ. The bus side can insert wait states and
// returns a two-cycle ERROR response for illegal accesses.
module ahb_vic_slave #(
  parameter int          N_IRQ        = 16,
  parameter int          WAIT_STATES  = 0,
  parameter logic [31:0] DEFAULT_VECT = 32'h0000_0000
) (
  input  logic             i_hclk,
  input  logic             i_hreset,
  input  logic [11:2]      i_haddr,
  input  logic             i_htrans,
  input  logic             i_hwrite,
  input  logic [2:0]       i_hsize,
  input  logic             i_hprot,
  input  logic [31:0]      i_hwdata,
  input  logic             i_hselvic,
  input  logic             i_hreadyin,
  output logic [31:0]      o_hrdata,
  output logic             o_hreadyout,
  output logic [1:0]       o_hresp,
  input  logic [N_IRQ-1:0] i_irqsrc,
  output logic             o_irq,
  output logic [31:0]      o_vector
);

  localparam int IW = (N_IRQ > 1) ? $clog2(N_IRQ) : 1;
  localparam logic [1:0] RESP_OKAY  = 2'b00;
  localparam logic [1:0] RESP_ERROR = 2'b01;
  localparam logic [9:0] VTAB_BASE  = 10'd64;              // byte offset 0x100
  localparam logic [9:0] VTAB_END   = 10'(64 + N_IRQ);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_ERR1,
    S_ERR2
  } state_t;

  // Bus-side state
  state_t      r_state;
  logic        r_hreadyout;
  logic [1:0]  r_hresp;
  logic [1:0]  r_wait_cnt;
  logic        r_dp_valid;   // a legal transfer is in its data phase
  logic        r_dp_write;
  logic [9:0]  r_dp_addr;

  // Controller registers
  logic [N_IRQ-1:0] r_enable;
  logic [N_IRQ-1:0] r_soft;
  logic [31:0]      r_vectaddr [N_IRQ];
  logic             r_inservice_valid;
  logic [IW-1:0]    r_inservice_idx;
  logic             r_irq;
  logic [31:0]      r_vector;

  // Combinational helpers
  logic             w_take;
  logic             w_mapped;
  logic             w_legal;
  logic             w_last;
  logic             w_wr_commit;
  logic             w_rd_commit;
  logic             w_is_vtab;
  logic [IW-1:0]    w_vidx;
  logic [N_IRQ-1:0] w_raw;
  logic [N_IRQ-1:0] w_active;
  logic             w_any;
  logic [IW-1:0]    w_win;
  logic [31:0]      w_vect_now;
  logic [31:0]      w_rdata;
  logic [N_IRQ-1:0] w_vtab_we;
  logic             w_unused_ok;

  // Address phase is only accepted when the slave is ready for a new transfer
  assign w_take   = i_hselvic & i_htrans & i_hreadyin &
                    ((r_state == S_IDLE) | (r_state == S_ERR2));
  assign w_mapped = (i_haddr <= 10'd5) ||
                    ((i_haddr >= VTAB_BASE) && (i_haddr < VTAB_END));
  assign w_legal  = (i_hsize == 3'b010) && w_mapped;

  // The last data-phase cycle is the one where a legal transfer sees HREADYOUT=1
  assign w_last      = r_dp_valid & r_hreadyout;
  assign w_wr_commit = w_last & r_dp_write;
  assign w_rd_commit = w_last & ~r_dp_write;

  assign w_is_vtab = (r_dp_addr >= VTAB_BASE) && (r_dp_addr < VTAB_END);
  assign w_vidx    = IW'(r_dp_addr - VTAB_BASE);

  assign w_raw    = i_irqsrc | r_soft;
  assign w_active = w_raw & r_enable;
  assign w_any    = |w_active;

  // Lowest-index active channel wins: scan downward so the last hit is the lowest
  always_comb begin
    w_win = '0;
    for (int i = N_IRQ - 1; i >= 0; i--) begin
      if (w_active[i]) w_win = IW'(i);
    end
  end

  assign w_vect_now = w_any ? r_vectaddr[w_win] : DEFAULT_VECT;

  // Read data multiplexer for the latched data-phase address
  always_comb begin
    w_rdata = '0;
    case (r_dp_addr)
      10'd0:   w_rdata = 32'(w_active);
      10'd1:   w_rdata = 32'(w_raw);
      10'd2:   w_rdata = 32'(r_enable);
      10'd3:   w_rdata = '0;
      10'd4:   w_rdata = 32'(r_soft);
      10'd5:   w_rdata = w_vect_now;
      default: if (w_is_vtab) w_rdata = r_vectaddr[w_vidx];
    endcase
  end

  // Per-channel write strobes for the vector table
  generate
    for (genvar gi = 0; gi < N_IRQ; gi++) begin : g_vtab_we
      assign w_vtab_we[gi] = w_wr_commit & w_is_vtab & (w_vidx == IW'(gi));
    end
  endgenerate

  // Transfer FSM: registered HREADYOUT/HRESP and data-phase capture
  always_ff @(posedge i_hclk or posedge i_hreset) begin
    if (i_hreset) begin
      r_state     <= S_IDLE;
      r_hreadyout <= 1'b1;
      r_hresp     <= RESP_OKAY;
      r_wait_cnt  <= '0;
      r_dp_valid  <= 1'b0;
      r_dp_write  <= 1'b0;
      r_dp_addr   <= '0;
    end else begin
      case (r_state)
        S_IDLE, S_ERR2: begin
          if (w_take) begin
            r_dp_write <= i_hwrite;
            r_dp_addr  <= i_haddr;
            if (w_legal) begin
              r_dp_valid <= 1'b1;
              r_hresp    <= RESP_OKAY;
              if (WAIT_STATES > 0) begin
                r_state     <= S_WAIT;
                r_hreadyout <= 1'b0;
                r_wait_cnt  <= 2'(WAIT_STATES - 1);
              end else begin
                r_state     <= S_IDLE;
                r_hreadyout <= 1'b1;
              end
            end else begin
              r_dp_valid  <= 1'b0;
              r_state     <= S_ERR1;
              r_hreadyout <= 1'b0;
              r_hresp     <= RESP_ERROR;
            end
          end else begin
            r_dp_valid  <= 1'b0;
            r_state     <= S_IDLE;
            r_hreadyout <= 1'b1;
            r_hresp     <= RESP_OKAY;
          end
        end
        S_WAIT: begin
          if (r_wait_cnt == 2'd0) begin
            r_hreadyout <= 1'b1;
            r_state     <= S_IDLE;
          end else begin
            r_wait_cnt <= r_wait_cnt - 2'd1;
          end
        end
        S_ERR1: begin
          r_hreadyout <= 1'b1;
          r_hresp     <= RESP_ERROR;
          r_state     <= S_ERR2;
        end
        default: begin
          r_state     <= S_IDLE;
          r_hreadyout <= 1'b1;
          r_hresp     <= RESP_OKAY;
        end
      endcase
    end
  end

  // Control registers: commit on the last data-phase cycle of a legal transfer
  always_ff @(posedge i_hclk or posedge i_hreset) begin
    if (i_hreset) begin
      r_enable          <= '0;
      r_soft            <= '0;
      r_inservice_valid <= 1'b0;
      r_inservice_idx   <= '0;
    end else begin
      if (w_wr_commit) begin
        case (r_dp_addr)
          10'd2:   r_enable <= r_enable | i_hwdata[N_IRQ-1:0];
          10'd3:   r_enable <= r_enable & ~i_hwdata[N_IRQ-1:0];
          10'd4:   r_soft   <= i_hwdata[N_IRQ-1:0];
          10'd5:   r_inservice_valid <= 1'b0;
          default: ;
        endcase
      end
      // Reading VECTADDR acknowledges the winner, unless nothing is active
      if (w_rd_commit && (r_dp_addr == 10'd5) && w_any) begin
        r_inservice_valid <= 1'b1;
        r_inservice_idx   <= w_win;
      end
    end
  end

  // Vector table storage
  always_ff @(posedge i_hclk or posedge i_hreset) begin
    if (i_hreset) begin
      for (int i = 0; i < N_IRQ; i++) r_vectaddr[i] <= '0;
    end else begin
      for (int i = 0; i < N_IRQ; i++) begin
        if (w_vtab_we[i]) r_vectaddr[i] <= i_hwdata;
      end
    end
  end

  // Core-facing outputs, registered for one cycle of latency
  always_ff @(posedge i_hclk or posedge i_hreset) begin
    if (i_hreset) begin
      r_irq    <= 1'b0;
      r_vector <= DEFAULT_VECT;
    end else begin
      r_irq    <= w_any & ~r_inservice_valid;
      r_vector <= w_vect_now;
    end
  end

  assign o_hrdata    = w_rd_commit ? w_rdata : 32'h0;
  assign o_hreadyout = r_hreadyout;
  assign o_hresp     = r_hresp;
  assign o_irq       = r_irq;
  assign o_vector    = r_vector;

  // HPROT has no meaning here; the in-service index is held for the ISR context only
  assign w_unused_ok = &{1'b0, i_hprot, r_inservice_idx};

endmodule

// File: tb/tb_ahb_vic_slave.sv
// Directed bench: dut0 has no wait states, dut1 has two. Both share one bus.
module tb_ahb_vic_slave;

  localparam logic [31:0] DEFV = 32'h0000_0F00;

  logic        clk;
  logic        rst;
  logic [11:2] haddr;
  logic        htrans, hwrite, hprot;
  logic [2:0]  hsize;
  logic [31:0] hwdata;
  logic        hsel0, hsel1;
  logic [15:0] irqsrc;
  logic [31:0] hrdata0, hrdata1, vector0, vector1;
  logic        hready0, hready1, irq0, irq1;
  logic [1:0]  hresp0, hresp1;
  bit          tgt;
  logic        hready_bus;
  logic [31:0] hrdata_bus;
  logic [1:0]  hresp_bus;

  int checks   = 0;
  int failures = 0;

  assign hready_bus = tgt ? hready1 : hready0;
  assign hrdata_bus = tgt ? hrdata1 : hrdata0;
  assign hresp_bus  = tgt ? hresp1  : hresp0;

  ahb_vic_slave #(.N_IRQ(16), .WAIT_STATES(0), .DEFAULT_VECT(DEFV)) dut0 (
    .i_hclk(clk), .i_hreset(rst), .i_haddr(haddr), .i_htrans(htrans),
    .i_hwrite(hwrite), .i_hsize(hsize), .i_hprot(hprot), .i_hwdata(hwdata),
    .i_hselvic(hsel0), .i_hreadyin(hready_bus), .o_hrdata(hrdata0),
    .o_hreadyout(hready0), .o_hresp(hresp0), .i_irqsrc(irqsrc),
    .o_irq(irq0), .o_vector(vector0));

  ahb_vic_slave #(.N_IRQ(16), .WAIT_STATES(2), .DEFAULT_VECT(DEFV)) dut1 (
    .i_hclk(clk), .i_hreset(rst), .i_haddr(haddr), .i_htrans(htrans),
    .i_hwrite(hwrite), .i_hsize(hsize), .i_hprot(hprot), .i_hwdata(hwdata),
    .i_hselvic(hsel1), .i_hreadyin(hready_bus), .o_hrdata(hrdata1),
    .o_hreadyout(hready1), .o_hresp(hresp1), .i_irqsrc(irqsrc),
    .o_irq(irq1), .o_vector(vector1));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One complete transfer; called and returns at posedge+1
  task automatic xfer(input bit t, input bit wr, input logic [11:0] addr,
                      input logic [2:0] size, input logic [31:0] wd,
                      output logic [31:0] rd, output int waits,
                      output logic [1:0] resp, output logic [1:0] resp_first);
    tgt = t; haddr = addr[11:2]; hwrite = wr; hsize = size; htrans = 1'b1;
    if (t) hsel1 = 1'b1; else hsel0 = 1'b1;
    @(posedge clk); #1;
    htrans = 1'b0; hsel0 = 1'b0; hsel1 = 1'b0; hwrite = 1'b0; hwdata = wd;
    waits = 0; rd = '0; resp = 2'b11; resp_first = 2'b11;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (c == 0) resp_first = hresp_bus;
      if (hready_bus) begin
        rd = hrdata_bus; resp = hresp_bus;
        $display("xfer dut%0d %s addr=%h size=%0d wdata=%h rdata=%h waits=%0d resp=%0d",
                 t, wr ? "W" : "R", addr, size, wd, rd, waits, resp);
        @(posedge clk); #1;
        return;
      end
      waits++;
      @(posedge clk); #1;
    end
    checks++; failures++;
    $display("FAIL xfer_timeout addr=%h got no HREADYOUT required HREADYOUT=1", addr);
  endtask

  task automatic wr(input bit t, input logic [11:0] addr, input logic [31:0] wd);
    logic [31:0] rd; int w; logic [1:0] r, rf;
    xfer(t, 1'b1, addr, 3'b010, wd, rd, w, r, rf);
  endtask

  task automatic rdw(input bit t, input logic [11:0] addr, output logic [31:0] rd, output int w);
    logic [1:0] r, rf;
    xfer(t, 1'b0, addr, 3'b010, 32'h0, rd, w, r, rf);
  endtask

  // Write immediately followed by a read, no idle cycle between them
  task automatic b2b(input bit t, input logic [11:0] waddr, input logic [31:0] wd,
                     input logic [11:0] raddr, output logic [31:0] rd,
                     output int wwaits, output int rwaits);
    tgt = t; haddr = waddr[11:2]; hwrite = 1'b1; hsize = 3'b010; htrans = 1'b1;
    if (t) hsel1 = 1'b1; else hsel0 = 1'b1;
    @(posedge clk); #1;
    hwdata = wd; haddr = raddr[11:2]; hwrite = 1'b0;
    wwaits = 0; rwaits = 0; rd = '0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (hready_bus) break;
      wwaits++;
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
    htrans = 1'b0; hsel0 = 1'b0; hsel1 = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (hready_bus) begin
        rd = hrdata_bus;
        $display("b2b dut%0d W %h=%h then R %h=%h wwaits=%0d rwaits=%0d",
                 t, waddr, wd, raddr, rd, wwaits, rwaits);
        @(posedge clk); #1;
        return;
      end
      rwaits++;
      @(posedge clk); #1;
    end
    checks++; failures++;
    $display("FAIL b2b_timeout got no HREADYOUT required HREADYOUT=1");
  endtask

  task automatic test_reset;
    logic [31:0] rd; int w;
    @(negedge clk);
    checks++; if (hready0 !== 1'b1) begin failures++; $display("FAIL rst_hready got=%b exp=1", hready0); end
    checks++; if (hresp0 !== 2'b00) begin failures++; $display("FAIL rst_hresp got=%b exp=00", hresp0); end
    checks++; if (irq0 !== 1'b0) begin failures++; $display("FAIL rst_irq got=%b exp=0", irq0); end
    checks++; if (vector0 !== DEFV) begin failures++; $display("FAIL rst_vector got=%h exp=%h", vector0, DEFV); end
    checks++; if (hrdata0 !== 32'h0) begin failures++; $display("FAIL rst_hrdata got=%h exp=0", hrdata0); end
    @(posedge clk); #1; rst = 1'b0;
    // Raise IRQ on dut1, then reset it in the middle of a wait-stated write
    wr(1'b1, 12'h008, 32'h1);
    irqsrc = 16'h0001;
    repeat (2) @(negedge clk);
    checks++; if (irq1 !== 1'b1) begin failures++; $display("FAIL pre_rst_irq got=%b exp=1", irq1); end
    @(posedge clk); #1;
    tgt = 1'b1; haddr = 10'h004; hwrite = 1'b1; hsize = 3'b010; htrans = 1'b1; hsel1 = 1'b1;
    @(posedge clk); #1;
    htrans = 1'b0; hsel1 = 1'b0; hwrite = 1'b0; hwdata = 32'h2;
    @(negedge clk);
    checks++; if (hready1 !== 1'b0) begin failures++; $display("FAIL midwait_hready got=%b exp=0", hready1); end
    #2 rst = 1'b1;
    #1;
    checks++; if (hready1 !== 1'b1) begin failures++; $display("FAIL async_rst_hready got=%b exp=1", hready1); end
    checks++; if (hresp1 !== 2'b00) begin failures++; $display("FAIL async_rst_hresp got=%b exp=00", hresp1); end
    checks++; if (irq1 !== 1'b0) begin failures++; $display("FAIL async_rst_irq got=%b exp=0", irq1); end
    checks++; if (vector1 !== DEFV) begin failures++; $display("FAIL async_rst_vector got=%h exp=%h", vector1, DEFV); end
    irqsrc = 16'h0;
    @(posedge clk); #1; rst = 1'b0;
    rdw(1'b1, 12'h010, rd, w);
    checks++; if (rd !== 32'h0) begin failures++; $display("FAIL rst_dropped_soft got=%h exp=0", rd); end
    rdw(1'b1, 12'h008, rd, w);
    checks++; if (rd !== 32'h0) begin failures++; $display("FAIL rst_enable_cleared got=%h exp=0", rd); end
  endtask

  task automatic test_regs;
    logic [31:0] rd; int w;
    wr(1'b0, 12'h108, 32'h0000_0400);
    wr(1'b0, 12'h008, 32'h4);
    rdw(1'b0, 12'h108, rd, w);
    checks++; if (rd !== 32'h0000_0400) begin failures++; $display("FAIL vectaddr2 got=%h exp=00000400", rd); end
    checks++; if (w !== 0) begin failures++; $display("FAIL zero_wait got=%0d exp=0", w); end
    rdw(1'b0, 12'h008, rd, w);
    checks++; if (rd !== 32'h4) begin failures++; $display("FAIL enable got=%h exp=4", rd); end
    wr(1'b0, 12'h008, 32'hFFFF_0000);
    rdw(1'b0, 12'h008, rd, w);
    checks++; if (rd !== 32'h4) begin failures++; $display("FAIL enable_hibits got=%h exp=4", rd); end
    rdw(1'b0, 12'h00C, rd, w);
    checks++; if (rd !== 32'h0) begin failures++; $display("FAIL enclear_read got=%h exp=0", rd); end
    wr(1'b0, 12'h00C, 32'h4);
    rdw(1'b0, 12'h008, rd, w);
    checks++; if (rd !== 32'h0) begin failures++; $display("FAIL enclear got=%h exp=0", rd); end
  endtask

  task automatic test_vector;
    logic [31:0] rd; int w;
    wr(1'b0, 12'h008, 32'h6);
    wr(1'b0, 12'h104, 32'h200);
    irqsrc = 16'h0006;
    @(negedge clk);
    checks++; if (irq0 !== 1'b0) begin failures++; $display("FAIL irq_latency got=%b exp=0", irq0); end
    @(negedge clk);
    checks++; if (irq0 !== 1'b1) begin failures++; $display("FAIL irq_raise got=%b exp=1", irq0); end
    checks++; if (vector0 !== 32'h200) begin failures++; $display("FAIL vector_prio got=%h exp=200", vector0); end
    @(posedge clk); #1;
    rdw(1'b0, 12'h000, rd, w);
    checks++; if (rd !== 32'h6) begin failures++; $display("FAIL irqstatus got=%h exp=6", rd); end
    rdw(1'b0, 12'h014, rd, w);
    checks++; if (rd !== 32'h200) begin failures++; $display("FAIL vectaddr_read got=%h exp=200", rd); end
    repeat (2) @(negedge clk);
    checks++; if (irq0 !== 1'b0) begin failures++; $display("FAIL inservice_irq got=%b exp=0", irq0); end
    @(posedge clk); #1;
    wr(1'b0, 12'h014, 32'h0);
    repeat (2) @(negedge clk);
    checks++; if (irq0 !== 1'b1) begin failures++; $display("FAIL eoi_irq got=%b exp=1", irq0); end
    @(posedge clk); #1;
    irqsrc = 16'h0004;
    repeat (2) @(negedge clk);
    checks++; if (vector0 !== 32'h400) begin failures++; $display("FAIL vector_ch2 got=%h exp=400", vector0); end
    @(posedge clk); #1;
    irqsrc = 16'h0;
    repeat (2) @(negedge clk);
    checks++; if (vector0 !== DEFV) begin failures++; $display("FAIL vector_none got=%h exp=%h", vector0, DEFV); end
    @(posedge clk); #1;
    rdw(1'b0, 12'h014, rd, w);
    checks++; if (rd !== DEFV) begin failures++; $display("FAIL vectaddr_none got=%h exp=%h", rd, DEFV); end
    irqsrc = 16'h0004;
    repeat (2) @(negedge clk);
    checks++; if (irq0 !== 1'b1) begin failures++; $display("FAIL no_inservice_set got=%b exp=1", irq0); end
    @(posedge clk); #1;
    irqsrc = 16'h0;
    repeat (2) @(posedge clk); #1;
  endtask

  task automatic test_error;
    logic [31:0] rd; int w; logic [1:0] r, rf;
    xfer(1'b0, 1'b1, 12'h008, 3'b000, 32'h1, rd, w, r, rf);
    checks++; if (rf !== 2'b01) begin failures++; $display("FAIL err1_resp got=%b exp=01", rf); end
    checks++; if (r !== 2'b01) begin failures++; $display("FAIL err2_resp got=%b exp=01", r); end
    checks++; if (w !== 1) begin failures++; $display("FAIL err_lowcycles got=%0d exp=1", w); end
    @(negedge clk);
    checks++; if (hresp0 !== 2'b00) begin failures++; $display("FAIL err_recover got=%b exp=00", hresp0); end
    @(posedge clk); #1;
    rdw(1'b0, 12'h008, rd, w);
    checks++; if (rd !== 32'h6) begin failures++; $display("FAIL err_no_write got=%h exp=6", rd); end
    xfer(1'b0, 1'b0, 12'h018, 3'b010, 32'h0, rd, w, r, rf);
    checks++; if (rf !== 2'b01 || r !== 2'b01 || w !== 1) begin failures++;
      $display("FAIL unmapped_018 got=%b/%b/%0d exp=01/01/1", rf, r, w); end
    checks++; if (rd !== 32'h0) begin failures++; $display("FAIL err_hrdata got=%h exp=0", rd); end
    xfer(1'b0, 1'b1, 12'h140, 3'b010, 32'h55, rd, w, r, rf);
    checks++; if (rf !== 2'b01 || r !== 2'b01) begin failures++;
      $display("FAIL unmapped_140 got=%b/%b exp=01/01", rf, r); end
    xfer(1'b1, 1'b0, 12'h018, 3'b010, 32'h0, rd, w, r, rf);
    checks++; if (rf !== 2'b01 || r !== 2'b01 || w !== 1) begin failures++;
      $display("FAIL err_ws2 got=%b/%b/%0d exp=01/01/1", rf, r, w); end
  endtask

  task automatic test_wait;
    logic [31:0] rd; int w, ww, rw;
    rdw(1'b1, 12'h008, rd, w);
    checks++; if (w !== 2) begin failures++; $display("FAIL ws_read_waits got=%0d exp=2", w); end
    b2b(1'b1, 12'h008, 32'h5, 12'h008, rd, ww, rw);
    checks++; if (rd !== 32'h5) begin failures++; $display("FAIL ws_b2b_data got=%h exp=5", rd); end
    checks++; if (ww !== 2 || rw !== 2) begin failures++; $display("FAIL ws_b2b_waits got=%0d/%0d exp=2/2", ww, rw); end
  endtask

  task automatic test_back_to_back;
    logic [31:0] rd; int ww, rw;
    b2b(1'b0, 12'h010, 32'h1, 12'h010, rd, ww, rw);
    checks++; if (rd !== 32'h1) begin failures++; $display("FAIL b2b_data got=%h exp=1", rd); end
    checks++; if (ww !== 0 || rw !== 0) begin failures++; $display("FAIL b2b_waits got=%0d/%0d exp=0/0", ww, rw); end
    b2b(1'b0, 12'h10C, 32'h800, 12'h010, rd, ww, rw);
    wr(1'b0, 12'h010, 32'h0);
  endtask

  task automatic test_soft;
    logic [31:0] rd; int w;
    irqsrc = 16'h0;
    wr(1'b0, 12'h010, 32'h8);
    wr(1'b0, 12'h008, 32'h8);
    repeat (2) @(negedge clk);
    checks++; if (irq0 !== 1'b1) begin failures++; $display("FAIL soft_irq got=%b exp=1", irq0); end
    checks++; if (vector0 !== 32'h800) begin failures++; $display("FAIL soft_vector got=%h exp=800", vector0); end
    @(posedge clk); #1;
    rdw(1'b0, 12'h004, rd, w);
    checks++; if (rd !== 32'h8) begin failures++; $display("FAIL rawstatus got=%h exp=8", rd); end
    wr(1'b0, 12'h00C, 32'h8);
    repeat (2) @(negedge clk);
    checks++; if (irq0 !== 1'b0) begin failures++; $display("FAIL enclear_irq got=%b exp=0", irq0); end
    checks++; if (vector0 !== DEFV) begin failures++; $display("FAIL enclear_vector got=%h exp=%h", vector0, DEFV); end
    @(posedge clk); #1;
  endtask

  initial begin
    rst = 1'b1; haddr = '0; htrans = 1'b0; hwrite = 1'b0; hprot = 1'b0;
    hsize = 3'b010; hwdata = '0; hsel0 = 1'b0; hsel1 = 1'b0; irqsrc = '0; tgt = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    test_reset;
    test_regs;
    test_vector;
    test_error;
    test_wait;
    test_back_to_back;
    test_soft;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
